act_skew_feeder: RTL and testbench



---
 rtl/act_skew_feeder_pkg.sv | 17 +
 rtl/skew_line.sv | 33 +++
 rtl/act_skew_feeder.sv | 122 ++++++++++++
 tb/tb_act_skew_feeder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/act_skew_feeder_pkg.sv
// Shared definitions for the west-edge activation feeder: global data width
// and FSM state encodings.
`ifndef DATA_W
`define DATA_W 8
`endif

package act_skew_feeder_pkg;

    localparam int unsigned DATA_W = `DATA_W;

    // Feeder FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-register shift chain with shift enable and asynchronous
// active-low clear. q is the last register of the chain.
// Ports: clk, rst_n, en (shift one stage), d (chain input), q (chain output).
module skew_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg [DEPTH];

    // Shift chain; holds when en is low so the whole array freezes together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stg[k] <= '0;
            end
        end else if (en) begin
            stg[0] <= d;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// act_skew_feeder: accepts activation vectors over valid/ready and re-times
// them into the diagonal skew of a weight-stationary systolic array (row i
// lags row 0 by i slots), then flushes 2*N-1 zero slots and pulses done.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, num_vec    tile start pulse and vector count (sampled in IDLE)
//   in_valid/in_ready input vector handshake (in_ready is combinational)
//   in_data           N lanes of DATA_W, lane i feeds row i
//   act_west          registered west-edge activations, same lane layout
//   compute           registered array advance enable
//   busy              high while streaming or flushing
//   done              one-cycle end-of-tile pulse
module act_skew_feeder
    import act_skew_feeder_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_vec,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    output logic [N*DATA_W-1:0] act_west,
    output logic                compute,
    output logic                busy,
    output logic                done
);

    localparam int unsigned FLUSH_CYC = 2*N - 1;
    localparam int unsigned FL_W      = $clog2(2*N);

    logic [1:0]          state, state_nxt;
    logic [CNT_W-1:0]    remaining, remaining_nxt;
    logic [FL_W-1:0]     flush_cnt, flush_cnt_nxt;
    logic                done_nxt, busy_nxt;
    logic                accept, advance;
    logic [N*DATA_W-1:0] chain_in;

    assign in_ready = (state == ST_STREAM) && (remaining != '0);
    assign accept   = in_valid && in_ready;
    assign advance  = accept || (state == ST_FLUSH);
    // Zeros enter the chains during flush so partial sums drain cleanly
    assign chain_in = (state == ST_STREAM) ? in_data : '0;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            flush_cnt <= '0;
            compute   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            flush_cnt <= flush_cnt_nxt;
            compute   <= advance;
            done      <= done_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        flush_cnt_nxt = flush_cnt;
        done_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (num_vec != '0) begin
                        remaining_nxt = num_vec;
                        state_nxt     = ST_STREAM;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt     = ST_FLUSH;
                        flush_cnt_nxt = FL_W'(FLUSH_CYC);
                    end
                end
            end
            ST_FLUSH: begin
                flush_cnt_nxt = flush_cnt - FL_W'(1);
                if (flush_cnt == FL_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt == ST_STREAM) || (state_nxt == ST_FLUSH);
    end

    // Lane i gets i skew stages plus the act_west output register
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(
            .DEPTH(i + 1),
            .W    (DATA_W)
        ) u_line (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (advance),
            .d    (chain_in[i*DATA_W +: DATA_W]),
            .q    (act_west[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder: the driver predicts the full slot
// sequence of each tile from the skew rule, a negedge monitor pops and
// compares every compute slot and every done pulse.
`ifndef DATA_W
`define DATA_W 8
`endif

module tb_act_skew_feeder;

    localparam int N     = 4;
    localparam int CNT_W = 16;
    localparam int DW    = `DATA_W;
    localparam int FLUSH = 2*N - 1;
    localparam int CW    = (N*DW > 32) ? N*DW : 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vec = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N*DW-1:0]  in_data = '0;
    logic [N*DW-1:0]  act_west;
    logic             compute, busy, done;

    int passed = 0;
    int total  = 0;

    logic [N*DW-1:0] exp_q[$];
    bit              exp_done_q[$];
    bit              mon_en = 1'b0;
    logic [N*DW-1:0] last_aw = '0;
    bit              prev_comp = 1'b0;

    always #5 clk = ~clk;

    act_skew_feeder #(.N(N), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .num_vec (num_vec),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .act_west(act_west),
        .compute (compute),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every compute slot and done pulse is scored against the queues
    always @(negedge clk) begin
        if (!rst_n) begin
            last_aw   = '0;
            prev_comp = 1'b0;
        end else if (mon_en) begin
            if (compute) begin
                if (exp_q.size() == 0) check("extra_compute", CW'(compute), CW'(0));
                else check("slot_act_west", CW'(act_west), CW'(exp_q.pop_front()));
            end else if (busy) begin
                check("stall_hold", CW'(act_west), CW'(last_aw));
            end
            if (done) begin
                if (exp_done_q.size() == 0) check("unexpected_done", CW'(done), CW'(0));
                else begin
                    bit after_comp;
                    after_comp = exp_done_q.pop_front();
                    check("done_after_compute", CW'(prev_comp), CW'(after_comp));
                    check("done_slots_drained", CW'(exp_q.size()), CW'(0));
                end
            end
            last_aw   = act_west;
            prev_comp = compute;
        end
    end

    // One tile: build vectors, predict every slot, drive with optional stalls
    task automatic run_tile(input int n, input int stall_pct, input int gap,
                            input bit fixed, input bit mid_start, input bit excess);
        logic [N*DW-1:0] v[$];
        logic [N*DW-1:0] w;
        int idx, cyc, rdy_cnt, gap_cnt, k;
        bit mid_done;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < N; i++) w[i*DW +: DW] = fixed ? DW'(i + 1) : DW'($urandom);
            v.push_back(w);
        end
        // Slot s (1-based): row i shows vector s-1-i when it exists, else zero
        for (int s = 1; s <= n + FLUSH; s++) begin
            for (int i = 0; i < N; i++) begin
                k = s - 1 - i;
                w[i*DW +: DW] = (k >= 0 && k < n) ? v[k][i*DW +: DW] : DW'(0);
            end
            exp_q.push_back(w);
        end
        exp_done_q.push_back(1'b1);

        @(negedge clk);
        start = 1'b1; num_vec = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; rdy_cnt = 0; gap_cnt = 0; mid_done = 1'b0;
        while (idx < n && cyc < 2000) begin
            if (gap_cnt > 0) begin
                in_valid = 1'b0; gap_cnt--;
            end else begin
                in_valid = ($urandom_range(99) >= stall_pct);
            end
            in_data = in_valid ? v[idx] : N*DW'($urandom);
            if (mid_start && idx == 1 && !mid_done) begin
                start = 1'b1; num_vec = CNT_W'(n + 5); mid_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (in_ready) rdy_cnt++;
            if (in_valid && in_ready) begin
                idx++;
                if (idx == 1) gap_cnt = gap;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("accepted_all", CW'(idx), CW'(n));
        if (stall_pct == 0 && gap == 0) check("ready_cycles", CW'(rdy_cnt), CW'(n));
        if (excess) begin
            in_valid = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #1 check("excess_ready", CW'(in_ready), CW'(0));
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        cyc = 0;
        while (exp_done_q.size() != 0 && cyc < 100) begin
            @(negedge clk); #1; cyc++;
        end
        check("tile_done", CW'(exp_done_q.size()), CW'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic zero_tile();
        @(negedge clk);
        start = 1'b1; num_vec = '0;
        exp_done_q.push_back(1'b0);
        @(negedge clk);
        start = 1'b0;
        check("zero_done", CW'(done), CW'(1));
        check("zero_no_compute", CW'(compute), CW'(0));
        repeat (5) @(negedge clk);
    endtask

    task automatic reset_mid();
        bit done_seen, comp_seen;
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1; num_vec = CNT_W'(6);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = N*DW'($urandom);
            @(negedge clk);
        end
        check("busy_before_reset", CW'(busy), CW'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_act_west", CW'(act_west), CW'(0));
        check("rst_compute", CW'(compute), CW'(0));
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_in_ready", CW'(in_ready), CW'(0));
        in_valid = 1'b0;
        exp_q.delete();
        exp_done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0; comp_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
            if (compute) comp_seen = 1'b1;
        end
        check("no_done_after_reset", CW'(done_seen), CW'(0));
        check("no_compute_after_reset", CW'(comp_seen), CW'(0));
        mon_en = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_act_west", CW'(act_west), CW'(0));
        check("reset_compute", CW'(compute), CW'(0));
        check("reset_done", CW'(done), CW'(0));
        check("reset_busy", CW'(busy), CW'(0));
        check("reset_in_ready", CW'(in_ready), CW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_tile(1, 0, 0, 1'b1, 1'b0, 1'b0);   // single vector, lanes {4,3,2,1}
        run_tile(3, 0, 0, 1'b0, 1'b0, 1'b1);   // back-to-back plus excess valid
        run_tile(2, 0, 3, 1'b0, 1'b0, 1'b0);   // three-cycle gap between vectors
        zero_tile();
        run_tile(4, 0, 0, 1'b0, 1'b1, 1'b0);   // start pulse while streaming
        for (int t = 0; t < 8; t++) begin
            run_tile($urandom_range(6, 1), 30, 0, 1'b0, 1'b0, t[0]);
        end
        reset_mid();
        run_tile(5, 20, 0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
